// File: rtl/rv32_mem_pkg.sv
// Shared types and constants for the RV32 data-memory responder.
package rv32_mem_pkg;

    localparam int XLEN   = 32;
    localparam int BE_W   = 4;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Misaligned, or outside [base, base + depth*4). Unsigned wrap makes
    // addresses below base land far out of range.
    function automatic logic addr_err(input logic [XLEN-1:0] addr,
                                      input logic [XLEN-1:0] base,
                                      input logic [XLEN-1:0] depth);
        logic [XLEN-1:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || ((off >> 2) >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-lane writes and a registered read port.
// The read register doubles as the response data register, so it can be
// cleared independently of the storage.
module dmem_array
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     we,
    input  logic [BE_W-1:0]          be,
    input  logic [XLEN-1:0]          wdata,
    input  logic                     re,
    input  logic                     clr,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem_r [DEPTH];
    logic [XLEN-1:0] rdata_r;

    // Byte-lane writes; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < BE_W; l++) begin
                if (be[l]) begin
                    mem_r[addr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read/data register: clear wins over read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_r <= {XLEN{1'b0}};
        end else if (clr) begin
            rdata_r <= {XLEN{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: valid/ready request in, valid/ready response out,
// programmable latency, one transaction outstanding.
module dmem_resp
    import rv32_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic       LAT_ZERO = (LATENCY == 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_e          state_r, state_nxt_s;
    logic [3:0]      cnt_r, cnt_nxt_s;
    logic            we_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] wdata_r;
    logic [BE_W-1:0] be_r;
    logic            rsp_valid_r, rsp_valid_nxt_s;
    logic            rsp_err_r, rsp_err_nxt_s;

    logic            accept_s, commit_s, clr_s;
    logic            cur_we_s;
    logic [XLEN-1:0] cur_addr_s;
    logic [XLEN-1:0] cur_wdata_s;
    logic [BE_W-1:0] cur_be_s;
    logic            err_s;
    logic [AW-1:0]   arr_addr_s;
    logic            arr_we_s, arr_re_s, arr_clr_s;

    // Commit uses the live request when committing on the accept edge
    // (zero latency), otherwise the latched request.
    always_comb begin
        if (state_r == IDLE) begin
            cur_we_s    = req_we;
            cur_addr_s  = req_addr;
            cur_wdata_s = req_wdata;
            cur_be_s    = req_be;
        end else begin
            cur_we_s    = we_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
            cur_be_s    = be_r;
        end
    end

    assign err_s      = addr_err(cur_addr_s, BASE_ADDR, 32'(DEPTH));
    assign arr_addr_s = AW'((cur_addr_s - BASE_ADDR) >> 2);

    // Next-state, counter and response-flag decode.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        accept_s        = 1'b0;
        commit_s        = 1'b0;
        clr_s           = 1'b0;
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_err_nxt_s   = rsp_err_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (LAT_ZERO) begin
                        commit_s    = 1'b1;
                        state_nxt_s = RESP;
                    end else begin
                        cnt_nxt_s   = LAT_LOAD;
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    commit_s    = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s     = IDLE;
                    clr_s           = 1'b1;
                    rsp_valid_nxt_s = 1'b0;
                    rsp_err_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                cnt_nxt_s       = 4'd0;
                clr_s           = 1'b1;
                rsp_valid_nxt_s = 1'b0;
                rsp_err_nxt_s   = 1'b0;
            end
        endcase
        if (commit_s) begin
            rsp_valid_nxt_s = 1'b1;
            rsp_err_nxt_s   = err_s;
        end else begin
            rsp_valid_nxt_s = rsp_valid_nxt_s;
        end
    end

    assign arr_we_s  = commit_s & cur_we_s & ~err_s;
    assign arr_re_s  = commit_s & ~cur_we_s & ~err_s;
    assign arr_clr_s = clr_s | (commit_s & (cur_we_s | err_s));

    // State, counter, response flags and request latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= {XLEN{1'b0}};
            wdata_r     <= {XLEN{1'b0}};
            be_r        <= {BE_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            if (accept_s) begin
                we_r    <= req_we;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                be_r    <= req_be;
            end
        end
    end

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (arr_addr_s),
        .we      (arr_we_s),
        .be      (cur_be_s),
        .wdata   (cur_wdata_s),
        .re      (arr_re_s),
        .clr     (arr_clr_s),
        .rdata   (rsp_rdata)
    );

    assign req_ready = (state_r == IDLE);
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;

endmodule
